// File: rtl/tbox_loader.sv
// Purpose: streams a 2^ADDR_W-word T-box into a table memory, reads the whole table back and checks its XOR checksum.
// Latency: start to done/error is 2^ADDR_W write cycles + 2^ADDR_W read cycles + 2 drain cycles when s_valid is never low.
// Backpressure: s_ready is high only while writing; s_valid low stalls the load indefinitely with no write issued.
//
// Ports:
//   bram_clk, rst          clock and asynchronous active-high reset
//   start                  begins a load from IDLE, DONE or ERR; ignored while busy
//   s_valid/s_data/s_ready upstream word stream, ascending address order
//   bram_we/addr/din/dout  table memory port (dout valid one cycle after addr is sampled)
//   busy/done/error        status; done and error are sticky until the next start
//   checksum               XOR of all accepted words
module tbox_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              bram_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] wr_xor;
  logic [DATA_W-1:0] rd_xor;
  logic [DATA_W-1:0] rd_xor_nxt;
  // rd_vld[0]: address issued last edge; rd_vld[1]: memory has sampled it,
  // so bram_dout holds that word during this cycle.
  logic [1:0]        rd_vld;

  // wr_xor only moves during WRITE, so it is both the live and the held checksum.
  assign checksum = wr_xor;

  always_comb begin
    rd_xor_nxt = rd_xor;
    if (rd_vld[1]) rd_xor_nxt = rd_xor ^ bram_dout;
  end

  always_ff @(posedge bram_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_xor    <= '0;
      rd_xor    <= '0;
      rd_vld    <= '0;
      s_ready   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      rd_vld  <= {rd_vld[0], 1'b0};
      rd_xor  <= rd_xor_nxt;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state   <= WRITE;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
            wr_xor  <= '0;
            rd_xor  <= '0;
            rd_vld  <= '0;
            cnt     <= '0;
          end
        end
        WRITE: begin
          if (s_valid && s_ready) begin
            bram_we   <= 1'b1;
            bram_addr <= cnt;
            bram_din  <= s_data;
            wr_xor    <= wr_xor ^ s_data;
            cnt       <= cnt + 1'b1;  // wraps to 0 after the last word, ready for readback
            if (cnt == LAST_ADDR) begin
              s_ready <= 1'b0;
              state   <= VERIFY;
            end
          end
        end
        VERIFY: begin
          bram_addr <= cnt;
          cnt       <= cnt + 1'b1;
          rd_vld    <= {rd_vld[0], 1'b1};
          if (cnt == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          // Only the final read result is still in flight: fold it in and decide.
          if (rd_vld == 2'b10) begin
            busy <= 1'b0;
            if (rd_xor_nxt == wr_xor) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tbox_loader.sv
module tb_tbox_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              bram_clk = 1'b0;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  tbox_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .bram_clk  (bram_clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  always #5 bram_clk = ~bram_clk;

  int cyc = 0;
  always @(posedge bram_clk) cyc <= cyc + 1;

  // Memory model: synchronous write, registered read, optional bit-0 flip at address 7.
  logic              corrupt = 1'b0;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge bram_clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr] ^ ((corrupt && bram_addr == 10'd7) ? 32'h1 : 32'h0);
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wexp_t;

  typedef struct packed {
    logic              done;
    logic              error;
    logic [DATA_W-1:0] cksum;
  } res_t;

  wexp_t wq[$];
  res_t  rq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    we_count = 0;
  logic  prev_busy = 1'b0;
  int    start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the expected write on every bram_we and the expected
  // outcome whenever busy falls.
  initial begin
    wexp_t w;
    res_t  r;
    forever begin
      @(negedge bram_clk);
      if (rst) begin
        prev_busy = 1'b0;
        we_count  = 0;
        wq.delete();
      end else begin
        if (bram_we) begin
          we_count++;
          if (wq.size() == 0) fail_now("unexpected_write");
          else begin
            w = wq.pop_front();
            check("wr_addr", 64'(bram_addr), 64'(w.addr));
            check("wr_data", 64'(bram_din), 64'(w.data));
          end
        end
        if (prev_busy && !busy) begin
          if (rq.size() == 0) fail_now("unexpected_completion");
          else begin
            r = rq.pop_front();
            check("res_done", 64'(done), 64'(r.done));
            check("res_error", 64'(error), 64'(r.error));
            check("res_checksum", 64'(checksum), 64'(r.cksum));
            check("res_we_pulses", 64'(we_count), 64'(DEPTH));
            check("res_pending_writes", 64'(wq.size()), 64'd0);
          end
          we_count = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic pulse_start();
    @(negedge bram_clk);
    start = 1'b1;
    @(posedge bram_clk);
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    int t = 0;
    @(negedge bram_clk);
    while (!s_ready && t < 100) begin
      @(negedge bram_clk);
      t++;
    end
    if (!s_ready) fail_now("s_ready_timeout");
    s_valid = 1'b1;
    s_data  = d;
    @(posedge bram_clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_bram_we"}, 64'(bram_we), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
    check({tag, "_bram_din"}, 64'(bram_din), 64'd0);
    check({tag, "_checksum"}, 64'(checksum), 64'd0);
  endtask

  // zeros: all-zero table with 1 at address 5; gap_after: word index followed
  // by a 20-cycle stall (-1 none); mid_start: pulse start during readback;
  // abort_after: word index after which rst is pulsed (-1 none).
  task automatic run_load(input bit zeros, input int gap_after, input bit corr,
                          input bit mid_start, input int abort_after);
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] xr;
    wexp_t w;
    res_t  r;
    int    t;
    int    last;
    int    lat;
    corrupt = corr;
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    check("start_error_clr", 64'(error), 64'd0);
    check("start_checksum_clr", 64'(checksum), 64'd0);
    xr   = '0;
    last = (abort_after >= 0) ? abort_after : DEPTH - 1;
    for (int i = 0; i <= last; i++) begin
      d = zeros ? ((i == 5) ? 32'h1 : 32'h0) : $urandom;
      xr ^= d;
      w.addr = i[ADDR_W-1:0];
      w.data = d;
      wq.push_back(w);
      send_word(d);
      if (i == gap_after) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge bram_clk);
          if (k > 0) check("gap_no_we", 64'(bram_we), 64'd0);
        end
      end
    end
    if (abort_after >= 0) begin
      @(negedge bram_clk);
      #2 rst = 1'b1;
      #1 check_all_zero("abort");
      @(posedge bram_clk);
      @(negedge bram_clk);
      #2 rst = 1'b0;
      return;
    end
    r.done  = !corr;
    r.error = corr;
    r.cksum = xr;
    rq.push_back(r);
    if (mid_start) begin
      repeat (50) @(negedge bram_clk);
      start = 1'b1;
      @(posedge bram_clk);
      #1 start = 1'b0;
      check("mid_start_busy", 64'(busy), 64'd1);
      check("mid_start_no_ready", 64'(s_ready), 64'd0);
    end
    t = 0;
    while (busy && t < 5000) begin
      @(negedge bram_clk);
      t++;
    end
    if (busy) fail_now("completion_timeout");
    else if (gap_after < 0 && !mid_start) begin
      lat = cyc - start_cyc;
      check("latency_in_range", 64'(lat > 2 * DEPTH && lat <= 2 * DEPTH + 3), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge bram_clk);
    @(negedge bram_clk);
    #2 rst = 1'b0;
    #1 check_all_zero("reset");

    run_load(1'b1, -1, 1'b0, 1'b0, -1);   // sparse table, back-to-back
    run_load(1'b1, 300, 1'b0, 1'b0, -1);  // restart from DONE, 20-cycle stall
    run_load(1'b0, -1, 1'b1, 1'b0, -1);   // readback corruption -> ERR
    run_load(1'b0, -1, 1'b0, 1'b1, -1);   // restart from ERR, start during readback
    run_load(1'b0, -1, 1'b0, 1'b0, 512);  // reset mid-WRITE
    run_load(1'b0, -1, 1'b0, 1'b0, -1);   // fresh load after reset

    repeat (5) @(negedge bram_clk);
    check("final_write_queue_empty", 64'(wq.size()), 64'd0);
    check("final_result_queue_empty", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tbox_loader.md
TBOX_LOADER -- requirements
Module: tbox_loader

Interface
REQ-001 Parameter: ADDR_W, 10, table address width; the table is 2^ADDR_W words, indexed {T_S,E_D,byte}.
REQ-002 Parameter: DATA_W, 32, table word width; one T-box entry per word.
REQ-003 bram_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins a load when the block is idle.
REQ-006 s_valid  input  1  the upstream word on s_data is valid.
REQ-007 s_data  input  DATA_W  table word, streamed in ascending address order.
REQ-008 s_ready  output  1  the block accepts s_data in this cycle.
REQ-009 bram_we  output  1  write enable to the table write port.
REQ-010 bram_addr  output  ADDR_W  registered table address for write and for readback.
REQ-011 bram_din  output  DATA_W  registered write data.
REQ-012 bram_dout  input  DATA_W  readback data; valid one cycle after bram_addr is sampled by the memory.
REQ-013 busy  output  1  a load or verify is in progress.
REQ-014 done  output  1  sticky; the load completed and the readback matched.
REQ-015 error  output  1  sticky; the readback checksum mismatched.
REQ-016 checksum  output  DATA_W  XOR of all accepted write words.

Function
REQ-017 FSM states: IDLE, WRITE, VERIFY, DRAIN, DONE, ERR.
REQ-018 IDLE: s_ready=0 and busy=0; start=1 -> WRITE; clears done, error, checksum, wr_xor, rd_xor and the address counter.
REQ-019 In DONE or ERR, start=1 re-enters WRITE with the same clears.
REQ-020 WRITE: s_ready=1; a transfer occurs on the edge where s_valid&s_ready=1.
REQ-021 Write transfer: next cycle bram_we=1, bram_addr=counter, bram_din=s_data; wr_xor ^= s_data; counter+1.
REQ-022 Cycles with s_valid=0 produce no write (bram_we=0); there is no limit on stall length.
REQ-023 Write of address 2^ADDR_W-1: s_ready=0 from the following cycle; counter wraps to 0; state -> VERIFY.
REQ-024 VERIFY: bram_we=0; bram_addr steps 0..2^ADDR_W-1, one per cycle; s_ready=0.
REQ-025 Readback capture: rd_xor ^= bram_dout on each cycle a read result is valid (2-stage valid pipeline matching the memory latency).
REQ-026 DRAIN: entered after the last address is issued; waits until the last read result is captured, then compares.
REQ-027 Compare: rd_xor==wr_xor -> DONE (done=1); otherwise -> ERR (error=1).
REQ-028 checksum shows wr_xor live during WRITE and holds its value afterward.
REQ-029 busy=1 in WRITE, VERIFY and DRAIN; start is ignored while busy=1.
REQ-030 done and error are never both 1.
REQ-031 Full load latency without stalls, start to done: 2^ADDR_W write cycles + 2^ADDR_W read cycles + pipeline drain, with drain ≤ 3 cycles.

Reset
REQ-032 rst=1 at any time, including mid-WRITE or mid-VERIFY, asynchronously forces IDLE.
REQ-033 The same reset forces s_ready, bram_we, busy, done and error to 0.
REQ-034 The same reset forces bram_addr, bram_din, checksum and internal XORs to 0.
REQ-035 After rst deasserts, a new start is required; a partial table is not resumed.

Verification
REQ-036 All 1024 words 0, except 32'h0000_0001 at address 5; memory model returns written data -> checksum=32'h1, done=1, error=0, bram_we pulses exactly 1024 times.
REQ-037 Same data, s_valid low for 20 cycles after word 300 -> no bram_we during the gap; addresses stay contiguous; result identical to REQ-036.
REQ-038 Memory model flips bit 0 of the word read at address 7 -> error=1, done=0, busy=0.
REQ-039 rst pulse after word 512 -> all outputs 0 next cycle; then start plus a full stream -> done=1.
REQ-040 start pulsed during VERIFY -> ignored; the sequence completes normally.
REQ-041 start in DONE -> done clears and checksum resets to 0; the second load completes.
